// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: valid/ready request port, FIFO store buffer with
// youngest-match load forwarding, lazy store drain and a registered load-miss path.
module load_store_unit #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          in_clk,
  input  logic          in_reset_n,
  input  logic          in_req_valid,
  output logic          out_req_ready,
  input  logic          in_req_write,
  input  logic [AW-1:0] in_req_addr,
  input  logic [DW-1:0] in_req_data,
  input  logic          in_drain,
  output logic          out_load_valid,
  output logic [DW-1:0] out_load_data,
  output logic          out_sb_empty,
  output logic          out_mem_read,
  output logic          out_mem_write,
  output logic [AW-1:0] out_mem_addr,
  output logic [DW-1:0] out_mem_data,
  input  logic [DW-1:0] in_mem_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t        state_r;
  logic [PW-1:0] head_r;
  logic [PW-1:0] tail_r;
  logic [CW-1:0] count_r;
  logic [AW-1:0] sb_addr_r [DEPTH];
  logic [DW-1:0] sb_data_r [DEPTH];
  logic [AW-1:0] load_addr_r;
  logic          load_valid_r;
  logic [DW-1:0] load_data_r;

  logic          full_s;
  logic          ready_s;
  logic          accept_s;
  logic          drain_s;
  logic          fwd_hit_s;
  logic [DW-1:0] fwd_data_s;
  logic [PW-1:0] fwd_idx_s;
  logic          fwd_match_s;

  // Handshake and drain qualification; ready is held low while reset is asserted.
  always_comb begin
    full_s   = (count_r == CW'(DEPTH));
    ready_s  = in_reset_n && (state_r == IDLE) && !full_s && !in_drain;
    accept_s = in_req_valid && ready_s;
    drain_s  = (state_r == IDLE) && (count_r != CW'(0)) &&
               (!in_req_valid || full_s || in_drain);
  end

  // Forwarding search from oldest to youngest so the youngest match overrides.
  always_comb begin
    fwd_hit_s   = 1'b0;
    fwd_data_s  = '0;
    fwd_idx_s   = '0;
    fwd_match_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx_s   = head_r + PW'(i);
      fwd_match_s = (CW'(i) < count_r) && (sb_addr_r[fwd_idx_s] == in_req_addr);
      fwd_hit_s   = fwd_match_s ? 1'b1 : fwd_hit_s;
      fwd_data_s  = fwd_match_s ? sb_data_r[fwd_idx_s] : fwd_data_s;
    end
  end

  // Data-memory port: miss read in LOAD, head write on a drain cycle, otherwise idle.
  always_comb begin
    out_mem_read  = 1'b0;
    out_mem_write = 1'b0;
    out_mem_addr  = '0;
    out_mem_data  = '0;
    if (state_r == LOAD) begin
      out_mem_read = 1'b1;
      out_mem_addr = load_addr_r;
    end else if (drain_s) begin
      out_mem_write = 1'b1;
      out_mem_addr  = sb_addr_r[head_r];
      out_mem_data  = sb_data_r[head_r];
    end else begin
      out_mem_read  = 1'b0;
      out_mem_write = 1'b0;
    end
  end

  // Control FSM, store-buffer state and registered load response.
  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_r      <= IDLE;
      head_r       <= '0;
      tail_r       <= '0;
      count_r      <= '0;
      load_addr_r  <= '0;
      load_valid_r <= 1'b0;
      load_data_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        sb_addr_r[i] <= '0;
        sb_data_r[i] <= '0;
      end
    end else begin
      load_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s && in_req_write) begin
            sb_addr_r[tail_r] <= in_req_addr;
            sb_data_r[tail_r] <= in_req_data;
            tail_r            <= tail_r + PW'(1);
            count_r           <= count_r + CW'(1);
          end else if (accept_s) begin
            if (fwd_hit_s) begin
              load_data_r  <= fwd_data_s;
              load_valid_r <= 1'b1;
            end else begin
              load_addr_r <= in_req_addr;
              state_r     <= LOAD;
            end
          end else if (drain_s) begin
            // Never coincides with an enqueue: drain only runs when nothing is accepted.
            head_r  <= head_r + PW'(1);
            count_r <= count_r - CW'(1);
          end
        end
        LOAD: begin
          load_data_r  <= in_mem_data;
          load_valid_r <= 1'b1;
          state_r      <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign out_req_ready  = ready_s;
  assign out_load_valid = load_valid_r;
  assign out_load_data  = load_data_r;
  assign out_sb_empty   = (count_r == CW'(0));

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit; memory returns its address as data.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        drain;
  logic        load_valid;
  logic [31:0] load_data;
  logic        sb_empty;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem_addr;

  load_store_unit #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .in_clk        (clk),
    .in_reset_n    (rst_n),
    .in_req_valid  (req_valid),
    .out_req_ready (req_ready),
    .in_req_write  (req_write),
    .in_req_addr   (req_addr),
    .in_req_data   (req_data),
    .in_drain      (drain),
    .out_load_valid(load_valid),
    .out_load_data (load_data),
    .out_sb_empty  (sb_empty),
    .out_mem_read  (mem_read),
    .out_mem_write (mem_write),
    .out_mem_addr  (mem_addr),
    .out_mem_data  (mem_wdata),
    .in_mem_data   (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then settle before checks.
  task automatic cyc(input logic v, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic dr);
    @(negedge clk);
    req_valid = v;
    req_write = w;
    req_addr  = a;
    req_data  = d;
    drain     = dr;
    #1;
  endtask

  task automatic check_write(input string tag, input logic [31:0] a, input logic [31:0] d);
    check({tag, "_wr"},   32'(mem_write), 32'd1);
    check({tag, "_addr"}, mem_addr, a);
    check({tag, "_data"}, mem_wdata, d);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 32'h0;
    req_data  = 32'h0;
    drain     = 1'b0;

    // Reset state
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("rst_ready",  32'(req_ready),  32'd0);
    check("rst_lvalid", 32'(load_valid), 32'd0);
    check("rst_ldata",  load_data,       32'h0);
    check("rst_empty",  32'(sb_empty),   32'd1);
    check("rst_mrd",    32'(mem_read),   32'd0);
    check("rst_mwr",    32'(mem_write),  32'd0);
    check("rst_maddr",  mem_addr,        32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_ready", 32'(req_ready), 32'd1);

    // Forwarding: store then load of the same address
    cyc(1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 1'b0);
    check("fwd_st_ready", 32'(req_ready), 32'd1);
    cyc(1'b1, 1'b0, 32'h100, 32'h0, 1'b0);
    check("fwd_ld_ready", 32'(req_ready), 32'd1);
    check("fwd_ld_mwr",   32'(mem_write), 32'd0);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("fwd_lvalid", 32'(load_valid), 32'd1);
    check("fwd_ldata",  load_data,       32'hDEADBEEF);
    check("fwd_mrd",    32'(mem_read),   32'd0);
    check_write("fwd_drain", 32'h100, 32'hDEADBEEF);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("fwd_empty",  32'(sb_empty),   32'd1);
    check("fwd_lpulse", 32'(load_valid), 32'd0);

    // Youngest-wins forwarding
    cyc(1'b1, 1'b1, 32'h20, 32'h11, 1'b0);
    cyc(1'b1, 1'b1, 32'h20, 32'h22, 1'b0);
    cyc(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    check("yw_ready", 32'(req_ready), 32'd1);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("yw_lvalid", 32'(load_valid), 32'd1);
    check("yw_ldata",  load_data,       32'h22);
    check_write("yw_drain0", 32'h20, 32'h11);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check_write("yw_drain1", 32'h20, 32'h22);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("yw_empty", 32'(sb_empty), 32'd1);

    // Miss path through the memory read port
    cyc(1'b1, 1'b0, 32'h45, 32'h0, 1'b0);
    check("miss_ready", 32'(req_ready), 32'd1);
    check("miss_mrd0",  32'(mem_read),  32'd0);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("miss_mrd1",   32'(mem_read),   32'd1);
    check("miss_maddr",  mem_addr,        32'h45);
    check("miss_busy",   32'(req_ready),  32'd0);
    check("miss_lv_early", 32'(load_valid), 32'd0);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("miss_mrd2",   32'(mem_read),   32'd0);
    check("miss_lvalid", 32'(load_valid), 32'd1);
    check("miss_ldata",  load_data,       32'h45);

    // Full buffer back-pressure (pointers wrap here)
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b1, 32'h80 + 32'(i), 32'hA0 + 32'(i), 1'b0);
      check("full_acc_ready", 32'(req_ready), 32'd1);
    end
    cyc(1'b1, 1'b1, 32'h84, 32'hA4, 1'b0);
    check("full_ready", 32'(req_ready), 32'd0);
    check_write("full_drain", 32'h80, 32'hA0);
    cyc(1'b1, 1'b1, 32'h84, 32'hA4, 1'b0);
    check("full_ready_back", 32'(req_ready), 32'd1);
    check("full_no_wr",      32'(mem_write), 32'd0);

    // Lazy drain in FIFO order once valid drops
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      check_write("lazy", 32'h81 + 32'(i), 32'hA1 + 32'(i));
    end
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("lazy_empty", 32'(sb_empty),  32'd1);
    check("lazy_idle",  32'(mem_write), 32'd0);

    // Fence drain with a request held valid
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 32'h30 + 32'(i), 32'h300 + 32'(i), 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 32'h99, 32'h0, 1'b1);
      check("fence_ready", 32'(req_ready), 32'd0);
      check("fence_nempty", 32'(sb_empty), 32'd0);
      check_write("fence", 32'h30 + 32'(i), 32'h300 + 32'(i));
    end
    cyc(1'b1, 1'b0, 32'h99, 32'h0, 1'b1);
    check("fence_empty",  32'(sb_empty),  32'd1);
    check("fence_ready2", 32'(req_ready), 32'd0);
    check("fence_idle",   32'(mem_write), 32'd0);

    // Reset with two buffered stores and a forwarded load in flight
    cyc(1'b1, 1'b1, 32'h50, 32'h500, 1'b0);
    cyc(1'b1, 1'b1, 32'h51, 32'h501, 1'b0);
    cyc(1'b1, 1'b0, 32'h51, 32'h0, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("mrst_empty",  32'(sb_empty),   32'd1);
    check("mrst_lvalid", 32'(load_valid), 32'd0);
    check("mrst_ldata",  load_data,       32'h0);
    check("mrst_mwr",    32'(mem_write),  32'd0);
    check("mrst_ready",  32'(req_ready),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mrst_ready1", 32'(req_ready), 32'd1);
    check("mrst_mwr1",   32'(mem_write), 32'd0);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("mrst_mwr2",   32'(mem_write), 32'd0);
    check("mrst_empty2", 32'(sb_empty),  32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit between the EX/MEM pipeline register and the data memory. It accepts one load or store request per cycle over a valid/ready handshake and buffers stores in a small FIFO store buffer. Buffered stores drain to the data memory lazily. Loads that hit the buffer are forwarded; loads that miss are sent to the data memory's combinational read port, with a registered response.

## Interface
- DEPTH, 4: store-buffer entries (power of 2, ≥2)
- AW, 32: address width
- DW, 32: data width

- in_clk  input  1  clock, rising edge
- in_reset_n  input  1  reset, asynchronous, active-low
- in_req_valid  input  1  request present
- out_req_ready  output  1  unit can accept a request this cycle
- in_req_write  input  1  1 = store, 0 = load
- in_req_addr  input  AW  word address
- in_req_data  input  DW  store data (ignored for loads)
- in_drain  input  1  fence/halt: empty the store buffer
- out_load_valid  output  1  one-cycle pulse, load result valid
- out_load_data  output  DW  load result
- out_sb_empty  output  1  store buffer empty
- out_mem_read  output  1  to data memory read strobe
- out_mem_write  output  1  to data memory write strobe
- out_mem_addr  output  AW  to data memory address
- out_mem_data  output  DW  to data memory write data
- in_mem_data  input  DW  from data memory, combinational read data

## Operation
- States: IDLE and LOAD.
  - IDLE -> LOAD when a load is accepted and misses the buffer.
  - LOAD -> IDLE unconditionally after one cycle.
- Handshake:
  - A request is accepted on a rising edge with in_req_valid & out_req_ready.
  - out_req_ready = (state==IDLE) & !full & !in_drain.
  - out_req_ready does not depend on in_req_valid.
- Store accept: enqueue {addr, data} at the tail; count+1.
- Load accept, forwarding check:
  - The check is combinational against all valid entries.
  - On multiple matches, the youngest entry wins.
  - Hit: register the entry's data into out_load_data; pulse out_load_valid the next cycle; no memory access.
  - Miss: latch the address and go to LOAD.
- LOAD cycle:
  - out_mem_read=1 and out_mem_addr = latched address.
  - in_mem_data is captured at the end of the cycle; out_load_valid pulses the following cycle.
- Drain cycle conditions: state==IDLE, buffer non-empty, and any of (in_req_valid==0, count==DEPTH, in_drain==1).
- Drain cycle actions:
  - out_mem_write=1, out_mem_addr/out_mem_data = head entry.
  - The head pops at the clock edge.
- Enqueue and pop never coincide, because drain only occurs when no request can be accepted.
- The memory port is idle otherwise: read=write=0, addr=data=0.
- Buffer wrap-around: head/tail pointers are log2(DEPTH) bits wrapping modulo DEPTH; count is log2(DEPTH)+1 bits.
- out_sb_empty = (count==0).
- Addresses pass through unmodified; no alignment or range checks.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - state=IDLE, count=0, pointers=0.
  - out_load_valid=0, out_load_data=0.
  - All out_mem_* = 0.
  - out_req_ready=1 once in_reset_n=1.
- Reset mid-operation: buffered stores are discarded and the in-flight load is dropped with no out_load_valid.
- Load hit latency: accept at edge N; out_load_valid high in cycle N+1.
- Load miss latency:
  - Accept at edge N.
  - out_mem_read high during cycle N+1, with out_req_ready=0 in that cycle.
  - out_load_valid high in cycle N+2.
- A request may be accepted in the same cycle out_load_valid is high.
- Store accept leaves the unit in IDLE; back-to-back stores are accepted at 1/cycle until full.
- Full: out_req_ready=0 and one entry drains per cycle. Ready returns the cycle after the pop.
- in_drain=1: ready=0 and one pop per cycle until empty. out_sb_empty rises the cycle after the last pop.
- in_drain during LOAD: the read completes first, then draining begins.

## Test plan
- Reset: assert in_reset_n=0 mid-stream with 2 buffered stores -> all outputs 0 and out_sb_empty=1 immediately. After release, out_req_ready=1 and no memory write occurs.
- Forwarding:
  - Store 0x100←0xDEADBEEF.
  - Next cycle, load 0x100 -> out_load_valid the next cycle with 0xDEADBEEF and no out_mem_read pulse.
- Youngest-wins: stores 0x20←0x11 then 0x20←0x22 back to back, then load 0x20 -> 0x22.
- Miss path:
  - With memory word 0x45 holding 0x45 and the buffer empty, load 0x45.
  - -> out_mem_read=1 for exactly one cycle with addr 0x45 and out_req_ready=0 that cycle.
  - -> out_load_valid two cycles after accept with 0x45.
- Full/back-pressure:
  - 5 back-to-back stores to 0x80..0x84 with DEPTH=4.
  - -> 4 accepted. The 5th sees ready=0 for one cycle while 0x80 drains (out_mem_write, data correct), then is accepted.
- Lazy drain and fence:
  - With 3 buffered stores, drop in_req_valid -> 3 consecutive write cycles in FIFO order.
  - Repeat using in_drain=1 with in_req_valid held high -> same order, ready=0 throughout, out_sb_empty rises after the third pop.
